// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader.
// State codes, acknowledge bytes and protocol framing constants.
package loader_pkg;

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_ACK  = 3'd2,
        S_RUN  = 3'd3,
        S_ERR  = 3'd4
    } state_e;

    localparam logic [7:0] ACK_OK_CODE  = 8'hAA;
    localparam logic [7:0] ACK_ERR_CODE = 8'hEE;
    localparam int         WORD_BYTES   = 4;

endpackage

// File: rtl/prog_loader_if.sv
// Single-port BRAM write bus shared by the loader and the core.
// master drives the port, slave observes it.
interface prog_loader_if #(
    parameter int ADDR_W = 8
);
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       din;

    modport master (output we, addr, din);
    modport slave  (input  we, addr, din);
endinterface

// File: rtl/word_packer.sv
// Little-endian byte-to-word packer; emits one registered word
// strobe the cycle after the fourth byte is accepted.
module word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam int IDX_W = $clog2(WORD_BYTES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORD_BYTES - 1);

    logic [IDX_W-1:0] idx;
    logic [23:0]      lo;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            idx        <= '0;
            lo         <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                idx <= '0;
            end else if (byte_valid) begin
                if (idx == LAST) begin
                    word       <= {byte_data, lo};
                    word_valid <= 1'b1;
                    idx        <= '0;
                end else begin
                    lo[{idx, 3'b000} +: 8] <= byte_data;
                    idx                    <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: receives a length-prefixed program over UART, fills
// the BRAM, acknowledges, then releases the core and hands over the port.
module prog_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W    = 8,
    parameter int         LOAD_BASE = 0,
    parameter logic [7:0] ACK_OK    = ACK_OK_CODE,
    parameter logic [7:0] ACK_ERR   = ACK_ERR_CODE
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    input  logic          tx_busy,
    output logic          tx_valid,
    output logic [7:0]    tx_data,
    output logic          core_rstn,
    prog_loader_if.slave  core,
    prog_loader_if.master mem,
    output logic          loading,
    output logic          load_err
);

    localparam logic [32:0] MAX_N =
        33'((64'd1 << ADDR_W) - 64'(LOAD_BASE));

    state_e          state_q, state_d;
    logic [31:0]     n_q, n_d;
    logic [ADDR_W:0] w_q, w_d;
    logic            tx_valid_q, tx_valid_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            sent_q, sent_d;

    logic            rx_open;
    logic            pk_valid;
    logic [31:0]     pk_word;
    logic            run;

    assign rx_open = (state_q == S_LEN) || (state_q == S_DATA);

    word_packer u_pack (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (!rx_open),
        .byte_valid (rx_valid && rx_open),
        .byte_data  (rx_data),
        .word_valid (pk_valid),
        .word       (pk_word)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_LEN;
            n_q        <= '0;
            w_q        <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            sent_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            w_q        <= w_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            sent_q     <= sent_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        w_d        = w_q;
        tx_valid_d = 1'b0;
        tx_data_d  = tx_data_q;
        sent_d     = sent_q;
        unique case (state_q)
            S_LEN: begin
                if (pk_valid) begin
                    n_d = pk_word;
                    if (pk_word == 32'd0)
                        state_d = S_ACK;
                    else if ({1'b0, pk_word} > MAX_N)
                        state_d = S_ERR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (pk_valid) begin
                    w_d = w_q + 1'b1;
                    if ((32'(w_q) + 32'd1) == n_q)
                        state_d = S_ACK;
                end
            end
            S_ACK: begin
                // strobe cycle stays in S_ACK so the core wakes one cycle later
                if (tx_valid_q) begin
                    state_d = S_RUN;
                end else if (!tx_busy) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = ACK_OK;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            S_ERR: begin
                if (!sent_q && !tx_busy) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = ACK_ERR;
                    sent_d     = 1'b1;
                end
            end
            default: begin
                state_d = S_LEN;
            end
        endcase
    end

    assign run       = (state_q == S_RUN);
    assign core_rstn = run;
    assign loading   = !run;
    assign load_err  = (state_q == S_ERR);
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;

    assign mem.we   = run ? core.we
                          : (pk_valid && (state_q == S_DATA));
    assign mem.addr = run ? core.addr
                          : ADDR_W'(LOAD_BASE) + w_q[ADDR_W-1:0];
    assign mem.din  = run ? core.din : pk_word;

endmodule
